res_frame_fifo: RTL and testbench

- Store-and-forward frame buffer that sits directly downstream of mat_process.
- Consumes its 8-bit result stream (data, VALID, LAST, READY) and buffers each result frame whole.
- Releases a frame downstream only after its LAST beat has been accepted, so consumers (DMA, UART packer) never see a partial matrix.
- Frames too large to ever fit are discarded and flagged.

---
 rtl/res_frame_fifo.sv | 88 ++++++++
 tb/tb_res_frame_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/res_frame_fifo.sv
// res_frame_fifo: store-and-forward result-frame buffer; frames are released only once
// their LAST beat is in, and frames that can never fit are discarded with a DROP pulse.
module res_frame_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic [DATA_W-1:0] S_AXIS_RES,
    input  logic              S_AXIS_VALID,
    input  logic              S_AXIS_LAST,
    output logic              S_AXIS_READY,
    output logic [DATA_W-1:0] M_AXIS_DATA,
    output logic              M_AXIS_VALID,
    output logic              M_AXIS_LAST,
    input  logic              M_AXIS_READY,
    output logic [ADDR_W:0]   FRAME_CNT,
    output logic              DROP
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {S_FILL, S_DROP} state_t;
    logic [DATA_W:0] mem [DEPTH];
    state_t state_q, state_d;
    logic [ADDR_W:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d, cnt_q, cnt_d;
    logic drop_q, drop_d, run_q;
    logic full, s_ready, s_acc, m_valid, m_acc, we, commit, rd_last;
    always_comb begin
        full     = (wr_q - rd_q) == (ADDR_W + 1)'(DEPTH);
        s_ready  = run_q && (state_q == S_DROP || !full || commit_q == rd_q);
        s_acc    = S_AXIS_VALID && s_ready;
        m_valid  = rd_q != commit_q;
        m_acc    = m_valid && M_AXIS_READY;
        rd_last  = mem[rd_q[ADDR_W-1:0]][DATA_W];
        state_d  = state_q;
        wr_d     = wr_q;
        commit_d = commit_q;
        rd_d     = m_acc ? rd_q + 1'b1 : rd_q;
        drop_d   = 1'b0;
        we       = 1'b0;
        commit   = 1'b0;
        if (s_acc) begin
            if (state_q == S_DROP) begin
                drop_d  = S_AXIS_LAST;
                state_d = S_AXIS_LAST ? S_FILL : S_DROP;
            end else if (!full) begin
                we       = 1'b1;
                wr_d     = wr_q + 1'b1;
                commit   = S_AXIS_LAST;
                commit_d = S_AXIS_LAST ? wr_q + 1'b1 : commit_q;
            end else begin
                // the partial frame already fills the whole buffer, so it can never commit
                wr_d    = commit_q;
                drop_d  = S_AXIS_LAST;
                state_d = S_AXIS_LAST ? S_FILL : S_DROP;
            end
        end
        cnt_d = cnt_q + (ADDR_W + 1)'(commit) - (ADDR_W + 1)'(m_acc && rd_last);
    end
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q  <= S_FILL;
            wr_q     <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            commit_q <= commit_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            run_q    <= 1'b1;
        end
    end
    always_ff @(posedge axis_clk) begin
        if (we) mem[wr_q[ADDR_W-1:0]] <= {S_AXIS_LAST, S_AXIS_RES};
    end
    // outputs are forced to zero whenever no committed beat is presented
    assign S_AXIS_READY = s_ready;
    assign M_AXIS_VALID = m_valid;
    assign M_AXIS_DATA  = m_valid ? mem[rd_q[ADDR_W-1:0]][DATA_W-1:0] : '0;
    assign M_AXIS_LAST  = m_valid && rd_last;
    assign FRAME_CNT    = cnt_q;
    assign DROP         = drop_q;
endmodule

// File: tb/tb_res_frame_fifo.sv
// tb_res_frame_fifo: directed bench for res_frame_fifo with an output scoreboard.
module tb_res_frame_fifo;
    logic       axis_clk = 1'b0;
    logic       axis_rst_n = 1'b0;
    logic [7:0] S_AXIS_RES = '0;
    logic       S_AXIS_VALID = 1'b0;
    logic       S_AXIS_LAST = 1'b0;
    logic       S_AXIS_READY;
    logic [7:0] M_AXIS_DATA;
    logic       M_AXIS_VALID;
    logic       M_AXIS_LAST;
    logic       M_AXIS_READY = 1'b0;
    logic [4:0] FRAME_CNT;
    logic       DROP;
    int n_chk = 0;
    int n_pass = 0;
    int drop_cnt = 0;
    int drop0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    res_frame_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .S_AXIS_RES(S_AXIS_RES), .S_AXIS_VALID(S_AXIS_VALID), .S_AXIS_LAST(S_AXIS_LAST),
        .S_AXIS_READY(S_AXIS_READY), .M_AXIS_DATA(M_AXIS_DATA), .M_AXIS_VALID(M_AXIS_VALID),
        .M_AXIS_LAST(M_AXIS_LAST), .M_AXIS_READY(M_AXIS_READY), .FRAME_CNT(FRAME_CNT), .DROP(DROP)
    );

    always #5 axis_clk = ~axis_clk;

    always @(negedge axis_clk) begin
        if (axis_rst_n) begin
            if (M_AXIS_VALID && M_AXIS_READY) got_q.push_back({M_AXIS_LAST, M_AXIS_DATA});
            if (DROP) drop_cnt++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input bit expect_out);
        int t = 0;
        bit done = 0;
        S_AXIS_VALID = 1'b1;
        S_AXIS_RES = d;
        S_AXIS_LAST = l;
        while (!done && t < 200) begin
            @(negedge axis_clk);
            if (S_AXIS_READY) begin
                @(posedge axis_clk);
                #1;
                done = 1;
            end
            t++;
        end
        if (!done) chk("send_timeout", 0, 1);
        else if (expect_out) exp_q.push_back({l, d});
        S_AXIS_VALID = 1'b0;
    endtask

    task automatic check_out(input string tag);
        int t = 0;
        while ((got_q.size() < exp_q.size() || M_AXIS_VALID) && t < 300) begin
            @(posedge axis_clk);
            #1;
            t++;
        end
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        idle(3);
        chk("rst_s_ready", S_AXIS_READY, 0);
        chk("rst_m_valid", M_AXIS_VALID, 0);
        chk("rst_frame_cnt", FRAME_CNT, 0);
        chk("rst_drop", DROP, 0);
        axis_rst_n = 1'b1;
        idle(2);

        M_AXIS_READY = 1'b1;
        send(8'h10, 0, 1);
        send(8'h20, 0, 1);
        send(8'h30, 0, 1);
        chk("basic_no_early_valid", M_AXIS_VALID, 0);
        send(8'h40, 1, 1);
        chk("basic_valid_next", M_AXIS_VALID, 1);
        chk("basic_cnt1", FRAME_CNT, 1);
        chk("basic_first_data", M_AXIS_DATA, 8'h10);
        check_out("basic");
        chk("basic_cnt0", FRAME_CNT, 0);

        M_AXIS_READY = 1'b0;
        for (int f = 0; f < 4; f++)
            for (int b = 0; b < 4; b++) send(8'(f * 16 + b + 1), b == 3, 1);
        chk("bp_cnt4", FRAME_CNT, 4);
        chk("bp_full_ready", S_AXIS_READY, 0);
        fork
            for (int b = 0; b < 4; b++) send(8'(8'hA1 + b), b == 3, 1);
            begin
                idle(3);
                chk("bp_stall", S_AXIS_READY, 0);
                M_AXIS_READY = 1'b1;
                idle(1);
                M_AXIS_READY = 1'b0;
                chk("bp_ready_back", S_AXIS_READY, 1);
                idle(3);
                M_AXIS_READY = 1'b1;
            end
        join
        check_out("bp");
        chk("bp_cnt0", FRAME_CNT, 0);

        drop0 = drop_cnt;
        for (int i = 0; i < 20; i++) send(8'(i + 1), i == 19, 0);
        chk("drop_pulse", DROP, 1);
        idle(1);
        chk("drop_pulse_end", DROP, 0);
        chk("drop_once", drop_cnt - drop0, 1);
        chk("drop_cnt0", FRAME_CNT, 0);
        check_out("drop_none");
        send(8'h10, 0, 1);
        send(8'h20, 0, 1);
        send(8'h30, 0, 1);
        send(8'h40, 1, 1);
        check_out("after_drop");

        drop0 = drop_cnt;
        M_AXIS_READY = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i + 1), i == 15, 1);
        chk("fit_cnt1", FRAME_CNT, 1);
        chk("fit_valid", M_AXIS_VALID, 1);
        M_AXIS_READY = 1'b1;
        check_out("fit");
        chk("fit_no_drop", drop_cnt - drop0, 0);

        for (int i = 0; i < 40; i++) send(8'(8'h10 * (i % 3 + 1)), i % 4 == 3, 1);
        check_out("wrap");
        send(8'hAB, 1, 1);
        check_out("single");

        M_AXIS_READY = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), i == 3, 0);
        send(8'hD0, 0, 0);
        send(8'hD1, 0, 0);
        chk("pre_rst_cnt1", FRAME_CNT, 1);
        axis_rst_n = 1'b0;
        #1;
        chk("mid_rst_s_ready", S_AXIS_READY, 0);
        chk("mid_rst_m_valid", M_AXIS_VALID, 0);
        chk("mid_rst_m_data", M_AXIS_DATA, 0);
        chk("mid_rst_m_last", M_AXIS_LAST, 0);
        chk("mid_rst_cnt", FRAME_CNT, 0);
        chk("mid_rst_drop", DROP, 0);
        idle(1);
        axis_rst_n = 1'b1;
        idle(2);
        got_q.delete();
        M_AXIS_READY = 1'b1;
        send(8'h55, 0, 1);
        send(8'h66, 1, 1);
        check_out("post_rst");
        chk("post_rst_cnt0", FRAME_CNT, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
